// File: rtl/mailbox_fifo_core_if.sv
// Access-port and stream-port bundle between the APB controller, the mailbox
// FIFO core and the consumer agent.
interface mailbox_fifo_core_if #(
    parameter int unsigned W_WIDTH_SYS = 32,
    parameter int unsigned WIDTH_ADDR  = 32
);
    logic                   req_w_i;
    logic                   req_r_i;
    logic [WIDTH_ADDR-1:0]  addr_i;
    logic [W_WIDTH_SYS-1:0] data_i;
    logic                   write_i;
    logic                   ack_w_o;
    logic                   ack_r_o;
    logic                   err_w_o;
    logic                   err_r_o;
    logic [W_WIDTH_SYS-1:0] rdata_o;
    logic                   m_valid_o;
    logic [W_WIDTH_SYS-1:0] m_data_o;
    logic                   m_ready_i;

    modport slave (
        input  req_w_i, req_r_i, addr_i, data_i, write_i, m_ready_i,
        output ack_w_o, ack_r_o, err_w_o, err_r_o, rdata_o, m_valid_o, m_data_o
    );

    modport master (
        output req_w_i, req_r_i, addr_i, data_i, write_i, m_ready_i,
        input  ack_w_o, ack_r_o, err_w_o, err_r_o, rdata_o, m_valid_o, m_data_o
    );
endinterface

// File: rtl/mailbox_fifo_core.sv
// Mailbox register/FIFO target: four-phase req/ack register access, message FIFO
// drained through a valid/ready stream, sticky overflow and a level interrupt.
module mailbox_fifo_core #(
    parameter int unsigned W_WIDTH_SYS = 32,
    parameter int unsigned WIDTH_ADDR  = 32,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic               pclk_i,
    input  logic               presetn_i,
    mailbox_fifo_core_if.slave bus,
    output logic               irq_o
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StAckW, StAckR} state_e;

    state_e                 state_q, state_d;
    logic [W_WIDTH_SYS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]        count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [1:0]             irq_en_q, irq_en_d;
    logic                   ack_w_q, ack_w_d, ack_r_q, ack_r_d;
    logic                   err_w_q, err_w_d, err_r_q, err_r_d;
    logic [W_WIDTH_SYS-1:0] rdata_q, rdata_d;
    logic [W_WIDTH_SYS-1:0] status, head;
    logic                   irq_q, irq_d;
    logic                   empty, full, dec_ok, push, pop, ovf_set, ovf_clr;
    logic [1:0]             sel;
    logic                   unused_write;

    assign unused_write = bus.write_i;
    assign empty  = (count_q == '0);
    assign full   = (count_q == CntW'(FIFO_DEPTH));
    assign dec_ok = (bus.addr_i[1:0] == 2'b00) && (bus.addr_i[WIDTH_ADDR-1:4] == '0);
    assign sel    = bus.addr_i[3:2];
    assign head   = mem_q[rd_ptr_q];
    assign pop    = bus.m_ready_i & ~empty;

    always_comb begin
        status       = '0;
        status[0]    = empty;
        status[1]    = full;
        status[2]    = ovf_q;
        status[15:8] = 8'(count_q);
    end

    always_comb begin
        state_d  = state_q;
        ack_w_d  = ack_w_q;
        ack_r_d  = ack_r_q;
        err_w_d  = err_w_q;
        err_r_d  = err_r_q;
        rdata_d  = rdata_q;
        irq_en_d = irq_en_q;
        push     = 1'b0;
        ovf_set  = 1'b0;
        ovf_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_w_i && bus.req_r_i) begin
                    // Conflicting requests: flag an error on the write side only.
                    ack_w_d = 1'b1;
                    err_w_d = 1'b1;
                    state_d = StAckW;
                end else if (bus.req_w_i) begin
                    ack_w_d = 1'b1;
                    err_w_d = 1'b0;
                    state_d = StAckW;
                    if (!dec_ok) begin
                        err_w_d = 1'b1;
                    end else begin
                        unique case (sel)
                            2'd0: begin
                                if (full) begin
                                    err_w_d = 1'b1;
                                    ovf_set = 1'b1;
                                end else begin
                                    push = 1'b1;
                                end
                            end
                            2'd1: err_w_d = 1'b1;
                            2'd2: irq_en_d = bus.data_i[1:0];
                            2'd3: ovf_clr = bus.data_i[2];
                        endcase
                    end
                end else if (bus.req_r_i) begin
                    ack_r_d = 1'b1;
                    err_r_d = 1'b0;
                    rdata_d = '0;
                    state_d = StAckR;
                    if (!dec_ok) begin
                        err_r_d = 1'b1;
                    end else begin
                        unique case (sel)
                            2'd0: begin
                                if (empty) err_r_d = 1'b1;
                                else       rdata_d = head;
                            end
                            2'd1: rdata_d = status;
                            2'd2: rdata_d = {{(W_WIDTH_SYS-2){1'b0}}, irq_en_q};
                            2'd3: rdata_d = '0;
                        endcase
                    end
                end
            end
            StAckW: begin
                if (!bus.req_w_i) begin
                    ack_w_d = 1'b0;
                    err_w_d = 1'b0;
                    state_d = StIdle;
                end
            end
            StAckR: begin
                if (!bus.req_r_i) begin
                    ack_r_d = 1'b0;
                    err_r_d = 1'b0;
                    rdata_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign count_d = count_q + CntW'(push) - CntW'(pop);
    // Set wins over a same-cycle clear.
    assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);
    assign irq_d   = (irq_en_d[0] & (count_d != '0)) | (irq_en_d[1] & ovf_d);

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 2'b00;
            ack_w_q  <= 1'b0;
            ack_r_q  <= 1'b0;
            err_w_q  <= 1'b0;
            err_r_q  <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            ack_w_q  <= ack_w_d;
            ack_r_q  <= ack_r_d;
            err_w_q  <= err_w_d;
            err_r_q  <= err_r_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_i;
    end

    assign bus.ack_w_o   = ack_w_q;
    assign bus.ack_r_o   = ack_r_q;
    assign bus.err_w_o   = err_w_q;
    assign bus.err_r_o   = err_r_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.m_valid_o = ~empty;
    assign bus.m_data_o  = empty ? '0 : head;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_mailbox_fifo_core.sv
// Directed bench for mailbox_fifo_core: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for key register reads.
module tb_mailbox_fifo_core;
    localparam int unsigned W     = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 8;

    logic pclk_i    = 1'b0;
    logic presetn_i = 1'b0;
    logic irq_o;

    mailbox_fifo_core_if #(.W_WIDTH_SYS(W), .WIDTH_ADDR(AW)) bus ();

    mailbox_fifo_core #(
        .W_WIDTH_SYS(W),
        .WIDTH_ADDR (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .pclk_i   (pclk_i),
        .presetn_i(presetn_i),
        .bus      (bus),
        .irq_o    (irq_o)
    );

    always #5 pclk_i = ~pclk_i;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: message queue, sticky overflow, enables, access phase.
    logic [31:0] mq[$];
    logic        m_ovf   = 1'b0;
    logic [1:0]  m_ien   = 2'b00;
    int          m_phase = 0;  // 0 free, 1 write access open, 2 read access open
    logic        e_ack_w = 1'b0, e_ack_r = 1'b0, e_err_w = 1'b0, e_err_r = 1'b0;
    logic [31:0] e_rdata = '0;
    logic        e_irq   = 1'b0;

    always @(posedge pclk_i or negedge presetn_i) begin : model
        int          pre_n, n_next;
        bit          do_pop, do_push, oset, oclr, bad;
        logic [31:0] a, pv;
        logic [1:0]  ien_n;
        logic        ovf_n;
        if (!presetn_i) begin
            mq.delete();
            m_ovf   <= 1'b0;
            m_ien   <= 2'b00;
            m_phase <= 0;
            e_ack_w <= 1'b0;
            e_ack_r <= 1'b0;
            e_err_w <= 1'b0;
            e_err_r <= 1'b0;
            e_rdata <= '0;
            e_irq   <= 1'b0;
        end else begin
            pre_n   = mq.size();
            do_pop  = bus.m_ready_i && (pre_n > 0);
            do_push = 0;
            oset    = 0;
            oclr    = 0;
            ien_n   = m_ien;
            pv      = bus.data_i;
            a       = bus.addr_i;
            bad     = (a % 4 != 0) || (a >= 16);
            if (m_phase == 0) begin
                if (bus.req_w_i && bus.req_r_i) begin
                    e_ack_w <= 1'b1;
                    e_err_w <= 1'b1;
                    m_phase <= 1;
                end else if (bus.req_w_i) begin
                    e_ack_w <= 1'b1;
                    m_phase <= 1;
                    if (bad || a == 4) e_err_w <= 1'b1;
                    else if (a == 0 && pre_n >= DEPTH) begin
                        e_err_w <= 1'b1;
                        oset = 1;
                    end else begin
                        e_err_w <= 1'b0;
                        if (a == 0) do_push = 1;
                        if (a == 8) ien_n = pv[1:0];
                        if (a == 12) oclr = pv[2];
                    end
                end else if (bus.req_r_i) begin
                    e_ack_r <= 1'b1;
                    m_phase <= 2;
                    e_err_r <= 1'b0;
                    e_rdata <= '0;
                    if (bad || (a == 0 && pre_n == 0)) e_err_r <= 1'b1;
                    else if (a == 0) e_rdata <= mq[0];
                    else if (a == 4)
                        e_rdata <= (pre_n == 0 ? 1 : 0) + (pre_n == DEPTH ? 2 : 0)
                                   + (m_ovf ? 4 : 0) + pre_n * 256;
                    else if (a == 8) e_rdata <= {30'd0, m_ien};
                end
            end else if (m_phase == 1 && !bus.req_w_i) begin
                e_ack_w <= 1'b0;
                e_err_w <= 1'b0;
                m_phase <= 0;
            end else if (m_phase == 2 && !bus.req_r_i) begin
                e_ack_r <= 1'b0;
                e_err_r <= 1'b0;
                m_phase <= 0;
            end
            if (do_pop) mq.delete(0);
            if (do_push) mq.push_back(pv);
            n_next = pre_n - (do_pop ? 1 : 0) + (do_push ? 1 : 0);
            ovf_n  = oset ? 1'b1 : (oclr ? 1'b0 : m_ovf);
            m_ovf  <= ovf_n;
            m_ien  <= ien_n;
            e_irq  <= (ien_n[0] && n_next > 0) || (ien_n[1] && ovf_n);
        end
    end

    always @(negedge pclk_i) begin
        check("ack_w", bus.ack_w_o, e_ack_w);
        check("ack_r", bus.ack_r_o, e_ack_r);
        if (e_ack_w) check("err_w", bus.err_w_o, e_err_w);
        if (e_ack_r) begin
            check("err_r", bus.err_r_o, e_err_r);
            check("rdata", bus.rdata_o, e_rdata);
        end
        check("m_valid", bus.m_valid_o, mq.size() != 0);
        if (mq.size() != 0) check("m_data", bus.m_data_o, mq[0]);
        check("irq", irq_o, e_irq);
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input bit with_pop, input bit both, output logic err);
        int n;
        @(posedge pclk_i); #1;
        bus.addr_i    = addr;
        bus.data_i    = data;
        bus.write_i   = 1'b1;
        bus.req_w_i   = 1'b1;
        bus.req_r_i   = both;
        bus.m_ready_i = with_pop;
        @(posedge pclk_i); #1;
        bus.m_ready_i = 1'b0;
        n = 0;
        while (!bus.ack_w_o && n < 20) begin @(negedge pclk_i); n++; end
        check("ack_w_seen", bus.ack_w_o, 1'b1);
        err = bus.err_w_o;
        repeat (2) @(posedge pclk_i);
        #1;
        bus.req_w_i = 1'b0;
        bus.req_r_i = 1'b0;
        n = 0;
        while (bus.ack_w_o && n < 20) begin @(negedge pclk_i); n++; end
        check("ack_w_drop", bus.ack_w_o, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic err, output logic [31:0] rd);
        int n;
        @(posedge pclk_i); #1;
        bus.addr_i  = addr;
        bus.write_i = 1'b0;
        bus.req_r_i = 1'b1;
        @(posedge pclk_i); #1;
        n = 0;
        while (!bus.ack_r_o && n < 20) begin @(negedge pclk_i); n++; end
        check("ack_r_seen", bus.ack_r_o, 1'b1);
        err = bus.err_r_o;
        rd  = bus.rdata_o;
        @(posedge pclk_i); #1;
        bus.req_r_i = 1'b0;
        n = 0;
        while (bus.ack_r_o && n < 20) begin @(negedge pclk_i); n++; end
        check("ack_r_drop", bus.ack_r_o, 1'b0);
    endtask

    logic [31:0] drain_exp[$];

    task automatic drain();
        int got;
        int n;
        got = 0;
        n   = 0;
        @(posedge pclk_i); #1;
        bus.m_ready_i = 1'b1;
        while (got < drain_exp.size() && n < 100) begin
            @(negedge pclk_i);
            if (bus.m_valid_o) begin
                check("drain_data", bus.m_data_o, drain_exp[got]);
                got++;
            end
            n++;
        end
        @(posedge pclk_i); #1;
        bus.m_ready_i = 1'b0;
        check("drain_count", got, drain_exp.size());
        @(negedge pclk_i);
        check("drain_empty", bus.m_valid_o, 1'b0);
        drain_exp.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        err;
        logic [31:0] rd;
        bus.req_w_i   = 1'b0;
        bus.req_r_i   = 1'b0;
        bus.addr_i    = '0;
        bus.data_i    = '0;
        bus.write_i   = 1'b0;
        bus.m_ready_i = 1'b0;
        repeat (3) @(posedge pclk_i);
        @(negedge pclk_i);
        check("rst_m_valid", bus.m_valid_o, 1'b0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_ack_w", bus.ack_w_o, 1'b0);
        check("rst_rdata", bus.rdata_o, 32'h0);
        presetn_i = 1'b1;

        do_write(32'h8, 32'h1, 0, 0, err);
        check("ien_wr_err", err, 1'b0);
        do_write(32'h0, 32'hDEAD_BEEF, 0, 0, err);
        check("push1_err", err, 1'b0);
        @(negedge pclk_i);
        check("push1_valid", bus.m_valid_o, 1'b1);
        check("push1_data", bus.m_data_o, 32'hDEAD_BEEF);
        check("push1_irq", irq_o, 1'b1);
        do_read(32'h4, err, rd);
        check("status_1", rd, 32'h0000_0100);

        for (int i = 1; i < 8; i++) begin
            do_write(32'h0, i, 0, 0, err);
            check("fill_err", err, 1'b0);
        end
        do_write(32'h8, 32'hFFFF_FFFE, 0, 0, err);
        @(negedge pclk_i);
        check("irq_ovf_only", irq_o, 1'b0);
        do_write(32'h0, 32'h9, 0, 0, err);
        check("push9_err", err, 1'b1);
        @(negedge pclk_i);
        check("irq_on_ovf", irq_o, 1'b1);
        do_read(32'h4, err, rd);
        check("status_full_ovf", rd, 32'h0000_0806);
        do_read(32'h8, err, rd);
        check("ien_read", rd, 32'h0000_0002);
        do_write(32'hC, 32'h4, 0, 0, err);
        check("clr_err", err, 1'b0);
        @(negedge pclk_i);
        check("irq_after_clr", irq_o, 1'b0);
        do_read(32'h4, err, rd);
        check("status_cleared", rd, 32'h0000_0802);
        do_write(32'h8, 32'h1, 0, 0, err);

        drain_exp = '{32'hDEAD_BEEF, 1, 2, 3, 4, 5, 6, 7};
        drain();

        do_read(32'h0, err, rd);
        check("peek_empty_err", err, 1'b1);
        check("peek_empty_data", rd, 32'h0);
        do_write(32'h0, 32'h5, 0, 0, err);
        do_read(32'h0, err, rd);
        check("peek_err", err, 1'b0);
        check("peek_data", rd, 32'h5);
        do_read(32'h4, err, rd);
        check("status_peek", rd, 32'h0000_0100);

        do_write(32'h0, 32'hA1, 0, 0, err);
        do_write(32'h0, 32'hA2, 0, 0, err);
        do_write(32'h0, 32'hA3, 1, 0, err);
        check("pushpop_err", err, 1'b0);
        do_read(32'h4, err, rd);
        check("status_pushpop", rd, 32'h0000_0300);
        for (int i = 0; i < 5; i++) do_write(32'h0, 32'hB0 + i, 0, 0, err);
        drain_exp = '{32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
        drain();
        for (int i = 0; i < 3; i++) do_write(32'h0, 32'hC0 + i, 0, 0, err);
        drain_exp = '{32'hC0, 32'hC1, 32'hC2};
        drain();

        do_write(32'h2, 32'h11, 0, 0, err);
        check("misaligned_err", err, 1'b1);
        do_read(32'h10, err, rd);
        check("oob_err", err, 1'b1);
        check("oob_data", rd, 32'h0);
        do_write(32'h4, 32'h22, 0, 0, err);
        check("status_wr_err", err, 1'b1);
        do_write(32'h0, 32'h33, 0, 1, err);
        check("both_req_err", err, 1'b1);
        @(negedge pclk_i);
        check("err_no_push", bus.m_valid_o, 1'b0);
        do_read(32'h4, err, rd);
        check("status_after_err", rd, 32'h0000_0001);

        do_write(32'h0, 32'h99, 0, 0, err);
        @(posedge pclk_i); #1;
        bus.addr_i  = 32'h0;
        bus.req_r_i = 1'b1;
        @(posedge pclk_i); #1;
        check("mid_ack_r", bus.ack_r_o, 1'b1);
        #2 presetn_i = 1'b0;
        #1;
        check("rst_ack_r", bus.ack_r_o, 1'b0);
        check("rst_irq_now", irq_o, 1'b0);
        check("rst_valid_now", bus.m_valid_o, 1'b0);
        bus.req_r_i = 1'b0;
        repeat (2) @(posedge pclk_i);
        @(negedge pclk_i);
        presetn_i = 1'b1;
        do_read(32'h4, err, rd);
        check("status_post_rst", rd, 32'h0000_0001);
        check("irq_post_rst", irq_o, 1'b0);

        repeat (2) @(posedge pclk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mailbox_fifo_core.md
Name: mailbox_fifo_core

Overview:
- Register/FIFO target downstream of the APB slave controller in the mailbox subsystem.
- Serves the controller's four-phase req/ack access port (req_w/req_r, addr, data, ack, err, rdata).
- Host writes to the DATA register push messages into a FIFO; a consumer agent drains them through a valid/ready stream port.
- Provides status, interrupt-enable and sticky-overflow registers, and drives an interrupt line.

Parameters:
- W_WIDTH_SYS, 32, data width of the access port, FIFO entries and stream port; must be ≥16.
- WIDTH_ADDR, 32, access-port address width.
- FIFO_DEPTH, 8, number of FIFO entries; power of two, 2..128.

Ports:
- pclk_i  in  1  clock, rising edge
- presetn_i  in  1  asynchronous active-low reset
- req_w_i  in  1  write request, held high until ack_w_o is seen
- req_r_i  in  1  read request, held high until ack_r_o is seen
- addr_i  in  WIDTH_ADDR  byte address, stable while a request is high
- data_i  in  W_WIDTH_SYS  write data, stable while req_w_i is high
- write_i  in  1  direction qualifier, informational only, not decoded
- ack_w_o  out  1  write acknowledge
- ack_r_o  out  1  read acknowledge
- err_w_o  out  1  write error, valid while ack_w_o=1
- err_r_o  out  1  read error, valid while ack_r_o=1
- rdata_o  out  W_WIDTH_SYS  read data, valid while ack_r_o=1
- m_valid_o  out  1  FIFO not empty
- m_data_o  out  W_WIDTH_SYS  FIFO head entry
- m_ready_i  in  1  consumer pop strobe, qualified by m_valid_o
- irq_o  out  1  registered interrupt, level

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; rdata_o=0.
  - FIFO empty, count=0, rd/wr pointers 0.
  - irq_en=2'b00, ovf=0, handshake FSM in IDLE.
- Handshake FSM states: IDLE, ACK_W, ACK_R.
- IDLE with req_w_i=1 and req_r_i=0, at edge k:
  - Perform the write and register err_w_o.
  - ack_w_o←1; go to ACK_W.
- IDLE with req_r_i=1 and req_w_i=0, at edge k:
  - Register rdata_o and err_r_o.
  - ack_r_o←1; go to ACK_R.
- IDLE with both requests high: ack_w_o←1, err_w_o←1, no side effect; go to ACK_W.
  - In ACK_W, a still-high req_r_i is ignored.
- ACK_W / ACK_R: hold ack, err and rdata until the matching req is sampled low.
  - Then ack←0, err←0; return to IDLE.
  - A new request is accepted no earlier than one cycle later.
- Each access has exactly one side effect, performed at the accept edge. No second access while ack is high.
- Decode error (err=1, no side effect):
  - addr_i[1:0]≠0, or addr_i[WIDTH_ADDR-1:4]≠0.
  - For reads, rdata_o=0.
- Register map, offset addr_i[3:2]:
  - 0x0 DATA
    - Write: push data_i if count<FIFO_DEPTH, else err_w_o=1, no push, ovf←1.
    - Read: peek head without pop; if empty, err_r_o=1 and rdata_o=0.
  - 0x4 STATUS, read-only; write → err_w_o=1.
    - [0] empty, [1] full, [2] ovf, [15:8] count, other bits 0.
  - 0x8 IRQ_EN, RW.
    - [0] enables not-empty interrupt, [1] enables overflow interrupt.
    - Other bits write-ignored, read 0.
  - 0xC IRQ_CLR
    - Write: data_i[2]=1 clears ovf; other bits ignored.
    - Read returns 0, no error.
- Full/empty and count:
  - Both are derived from the registered count at the start of the cycle.
  - Push when full is rejected even if the stream pops in the same cycle.
- Stream pop:
  - m_valid_o = !empty (combinational from registered state); m_data_o = head entry.
  - Pop at the edge where m_valid_o & m_ready_i.
  - m_ready_i while empty is ignored.
- Simultaneous push and pop: both happen; count is unchanged; pointers each advance.
- Pointers wrap modulo FIFO_DEPTH.
- A DATA read peek in the same cycle as a stream pop returns the pre-pop head.
- irq_o registered as (irq_en[0] & !empty) | (irq_en[1] & ovf), using next-state values.
  - Consequence: irq_o rises in the same cycle the push acks.
- ovf set and cleared in the same cycle: set wins.
- Reset mid-handshake: ack/err drop immediately. The requester must restart its access.

Test Plan:
- Reset, then write 0x8=0x1 and push 0xDEADBEEF to 0x0:
  - ack_w_o rises the cycle after req_w_i is sampled, err_w_o=0.
  - m_valid_o=1, m_data_o=0xDEADBEEF, irq_o=1.
  - ack_w_o holds until req_w_i falls, then drops.
- Push 8 words (FIFO_DEPTH=8), then push a 9th:
  - 9th ack has err_w_o=1.
  - STATUS read = 0x0806 (count=8, full, ovf).
  - Write 0xC=0x4 → ovf=0.
- Read 0x0 with FIFO empty → err_r_o=1, rdata_o=0. Read 0x0 after pushing 0x5 → rdata_o=0x5, count stays 1.
- FIFO holds 3 entries; push and m_ready_i=1 in the same cycle → count stays 3, pointers advance. Drain 11 entries across a pointer wrap → data in order, m_valid_o=0 at end.
- Misaligned addr 0x2, addr 0x10, write to 0x4, and req_w_i/req_r_i both high → each ack has err=1 with no state change.
- Assert presetn_i low while ack_r_o=1 → ack_r_o, irq_o and m_valid_o are 0 immediately; STATUS reads 0x0001 after release.
